// File: rtl/codec_config_sequencer_if.sv
// rtl/codec_config_sequencer_if.sv - write-command handshake between sequencer and I2C engine
interface codec_config_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_data;
    logic       cmd_done;
    logic       cmd_ack_failed;

    modport master (
        output cmd_valid, cmd_dev_addr, cmd_reg_addr, cmd_data,
        input  cmd_ready, cmd_done, cmd_ack_failed
    );

    modport slave (
        input  cmd_valid, cmd_dev_addr, cmd_reg_addr, cmd_data,
        output cmd_ready, cmd_done, cmd_ack_failed
    );
endinterface

// File: rtl/codec_config_sequencer.sv
// rtl/codec_config_sequencer.sv - walks a ROM table of register writes and delays, retrying NACKed writes
module codec_config_sequencer #(
    parameter int         NUM_ENTRIES = 11,
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         MAX_RETRY   = 3,
    parameter int         RETRY_GAP   = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic [5:0]                   rom_addr,
    input  logic [16:0]                  rom_data,
    codec_config_sequencer_if.master     cmd,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [5:0]                   fail_index
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT_DONE,
        S_DELAY,
        S_GAP
    } state_t;

    localparam logic [5:0]  LAST_IDX  = 6'(NUM_ENTRIES - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
    localparam int          GAP_M1    = (RETRY_GAP > 0) ? RETRY_GAP - 1 : 0;
    localparam logic [31:0] GAP_LOAD  = 32'(GAP_M1);

    state_t      r_state;
    logic [5:0]  r_index;
    logic [7:0]  r_retry;
    logic [15:0] r_entry;
    logic [31:0] r_cnt;
    logic        r_done;
    logic        r_error;
    logic [5:0]  r_fail_index;

    state_t      w_state_nxt;
    logic [5:0]  w_index_nxt;
    logic [7:0]  w_retry_nxt;
    logic [15:0] w_entry_nxt;
    logic [31:0] w_cnt_nxt;
    logic        w_done_nxt;
    logic        w_error_nxt;
    logic [5:0]  w_fail_nxt;
    logic        w_advance;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_index      <= '0;
            r_retry      <= '0;
            r_entry      <= '0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_fail_index <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_retry      <= w_retry_nxt;
            r_entry      <= w_entry_nxt;
            r_cnt        <= w_cnt_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_fail_index <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_retry_nxt = r_retry;
        w_entry_nxt = r_entry;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = r_done;
        w_error_nxt = r_error;
        w_fail_nxt  = r_fail_index;
        w_advance   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_done_nxt  = 1'b0;
                    w_error_nxt = 1'b0;
                    w_fail_nxt  = '0;
                    w_index_nxt = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: begin
                // rom_data answers the address presented during FETCH
                w_entry_nxt = rom_data[15:0];
                if (rom_data[16]) begin
                    w_cnt_nxt   = {16'd0, rom_data[15:0]};
                    w_state_nxt = S_DELAY;
                end else begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd.cmd_ready) w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (cmd.cmd_done) begin
                    if (!cmd.cmd_ack_failed) begin
                        w_retry_nxt = '0;
                        w_advance   = 1'b1;
                    end else if (r_retry < RETRY_MAX) begin
                        w_retry_nxt = r_retry + 8'd1;
                        if (RETRY_GAP == 0) begin
                            w_state_nxt = S_ISSUE;
                        end else begin
                            w_cnt_nxt   = GAP_LOAD;
                            w_state_nxt = S_GAP;
                        end
                    end else begin
                        w_error_nxt = 1'b1;
                        w_fail_nxt  = r_index;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DELAY: begin
                if (r_cnt == 32'd0) w_advance = 1'b1;
                else                w_cnt_nxt = r_cnt - 32'd1;
            end
            S_GAP: begin
                if (r_cnt == 32'd0) w_state_nxt = S_ISSUE;
                else                w_cnt_nxt   = r_cnt - 32'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_advance) begin
            if (r_index == LAST_IDX) begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end else begin
                w_index_nxt = r_index + 6'd1;
                w_state_nxt = S_FETCH;
            end
        end
    end

    assign rom_addr         = r_index;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign error            = r_error;
    assign fail_index       = r_fail_index;
    assign cmd.cmd_valid    = (r_state == S_ISSUE);
    assign cmd.cmd_dev_addr = DEV_ADDR;
    assign cmd.cmd_reg_addr = r_entry[15:8];
    assign cmd.cmd_data     = r_entry[7:0];

endmodule

// File: tb/tb_codec_config_sequencer.sv
// tb/tb_codec_config_sequencer.sv - directed table-driven bench for codec_config_sequencer
module tb_codec_config_sequencer;
    localparam int         NE = 6;
    localparam int         MR = 3;
    localparam int         RG = 16;
    localparam logic [6:0] DA = 7'h1A;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  rom_addr;
    logic [16:0] rom_data;
    logic        busy, seq_done, seq_error;
    logic [5:0]  fail_index;
    logic        cmd_ready, eng_done, eng_nack, stray_done, stray_nack;

    codec_config_sequencer_if bus();
    assign bus.cmd_ready      = cmd_ready;
    assign bus.cmd_done       = eng_done | stray_done;
    assign bus.cmd_ack_failed = eng_nack | stray_nack;

    always #5 clk = ~clk;

    codec_config_sequencer #(
        .NUM_ENTRIES(NE), .DEV_ADDR(DA), .MAX_RETRY(MR), .RETRY_GAP(RG)
    ) dut (
        .clock(clk), .reset(rst), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .cmd(bus.master),
        .busy(busy), .done(seq_done), .error(seq_error), .fail_index(fail_index)
    );

    logic [16:0] rom [0:63];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Engine model: done arrives lat clocks after accept; NACKs the first plan[reg] attempts.
    int   plan [0:255];
    int   used [0:255];
    int   lat = 20;
    int   pend;
    logic nk_r;
    always @(posedge clk) begin
        eng_done <= 1'b0;
        eng_nack <= 1'b0;
        if (rst) begin
            pend <= 0;
            nk_r <= 1'b0;
            for (int i = 0; i < 256; i++) used[i] <= 0;
        end else if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                eng_done <= 1'b1;
                eng_nack <= nk_r;
            end
        end else if (bus.cmd_valid && bus.cmd_ready) begin
            pend <= lat - 1;
            nk_r <= (used[bus.cmd_reg_addr] < plan[bus.cmd_reg_addr]);
            used[bus.cmd_reg_addr] <= used[bus.cmd_reg_addr] + 1;
        end
    end

    typedef struct {
        int         cyc;
        logic [6:0] dev;
        logic [7:0] ra;
        logic [7:0] d;
    } acc_t;
    acc_t acc_q[$];
    int cyc = 0, dly_cnt = 0, dly_vld = 0, cnt5 = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.cmd_valid && bus.cmd_ready)
            acc_q.push_back('{cyc, bus.cmd_dev_addr, bus.cmd_reg_addr, bus.cmd_data});
        if (busy && rom_addr == 6'd1) dly_cnt <= dly_cnt + 1;
        if (busy && rom_addr == 6'd1 && bus.cmd_valid) dly_vld <= dly_vld + 1;
        if (busy && rom_addr == 6'd5) cnt5 <= cnt5 + 1;
    end

    typedef struct {
        int          scen;
        int          idx;
        logic [16:0] word;
        int          nacks;
        int          issues;
    } vec_t;
    vec_t vecs[$];
    int   gap_q[$];
    int   n_checks = 0, n_fail = 0;

    function automatic logic [16:0] wr(input logic [7:0] r, input logic [7:0] d);
        return {1'b0, r, d};
    endfunction

    function automatic logic [16:0] dl(input logic [15:0] n);
        return {1'b1, n};
    endfunction

    task automatic addv(input int s, input int i, input logic [16:0] w, input int nk, input int ex);
        vecs.push_back('{s, i, w, nk, ex});
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load(input int s);
        for (int i = 0; i < 64; i++) rom[i] = '0;
        for (int j = 0; j < 256; j++) plan[j] = 0;
        foreach (vecs[k]) if (vecs[k].scen == s) begin
            rom[vecs[k].idx] = vecs[k].word;
            if (!vecs[k].word[16]) plan[vecs[k].word[15:8]] = vecs[k].nacks;
        end
        acc_q.delete();
        gap_q.delete();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(nm, 64'(busy), 64'(0));
    endtask

    task automatic run_check(input int s);
        acc_t r;
        foreach (vecs[k]) if (vecs[k].scen == s) begin
            for (int j = 0; j < vecs[k].issues; j++) begin
                if (acc_q.size() == 0) begin
                    check($sformatf("s%0d_e%0d_missing", s, vecs[k].idx), 64'(0), 64'(1));
                end else begin
                    r = acc_q.pop_front();
                    if (vecs[k].issues > 1) gap_q.push_back(r.cyc);
                    check($sformatf("s%0d_e%0d_cmd%0d", s, vecs[k].idx, j),
                          64'({r.dev, r.ra, r.d}), 64'({DA, vecs[k].word[15:0]}));
                end
            end
        end
        check($sformatf("s%0d_extra_cmds", s), 64'(acc_q.size()), 64'(0));
    endtask

    initial begin
        logic [22:0] f;
        int          d0, v0, c5, n;
        logic        stable;

        rst = 1'b1; start = 1'b0; cmd_ready = 1'b1; stray_done = 1'b0; stray_nack = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = '0;
        for (int j = 0; j < 256; j++) plan[j] = 0;

        addv(1, 0, wr(8'h10, 8'hA1), 0, 1); addv(1, 1, dl(16'd100), 0, 0);
        addv(1, 2, wr(8'h12, 8'hC3), 0, 1); addv(1, 3, wr(8'h13, 8'hD4), 0, 1);
        addv(1, 4, wr(8'h14, 8'hE5), 0, 1); addv(1, 5, wr(8'h15, 8'hF6), 0, 1);
        addv(2, 0, wr(8'h20, 8'h01), 0, 1); addv(2, 1, wr(8'h21, 8'h02), 0, 1);
        addv(2, 2, wr(8'h22, 8'h03), 2, 3); addv(2, 3, wr(8'h23, 8'h04), 0, 1);
        addv(2, 4, wr(8'h24, 8'h05), 0, 1); addv(2, 5, wr(8'h25, 8'h06), 0, 1);
        addv(3, 0, wr(8'h30, 8'h11), 0, 1); addv(3, 1, wr(8'h31, 8'h22), 0, 1);
        addv(3, 2, wr(8'h32, 8'h33), 0, 1); addv(3, 3, wr(8'h33, 8'h44), 0, 1);
        addv(3, 4, wr(8'h34, 8'h55), 255, 4); addv(3, 5, wr(8'h35, 8'h66), 0, 0);
        addv(4, 0, wr(8'h40, 8'h5A), 0, 1); addv(4, 1, wr(8'h41, 8'hA5), 0, 1);
        addv(4, 2, wr(8'h42, 8'h0F), 0, 1); addv(4, 3, wr(8'h43, 8'hF0), 0, 1);
        addv(4, 4, wr(8'h44, 8'h3C), 0, 1); addv(4, 5, wr(8'h45, 8'hC3), 0, 1);

        tick(); tick();
        check("reset_state", 64'({busy, seq_done, seq_error, bus.cmd_valid, rom_addr, fail_index}), 64'(0));
        rst = 1'b0;

        // Writes plus a 100-count delay, with start-to-command latency.
        load(1); lat = 20; d0 = dly_cnt; v0 = dly_vld;
        start_pulse();
        check("lat_t1_busy_addr", 64'({busy, rom_addr, bus.cmd_valid}), 64'({1'b1, 6'd0, 1'b0}));
        tick();
        check("lat_t2_no_valid", 64'(bus.cmd_valid), 64'(0));
        tick();
        check("lat_t3_valid", 64'(bus.cmd_valid), 64'(1));
        wait_idle("s1_finish", 2000);
        check("s1_done_err_busy", 64'({seq_done, seq_error, busy}), 64'(3'b100));
        check("s1_delay_clocks", 64'(dly_cnt - d0), 64'(103));
        check("s1_valid_in_delay", 64'(dly_vld - v0), 64'(0));
        run_check(1);

        // Entry 2 NACKs twice then ACKs.
        do_reset(); load(2); lat = 5;
        start_pulse();
        wait_idle("s2_finish", 3000);
        check("s2_done_err", 64'({seq_done, seq_error}), 64'(2'b10));
        run_check(2);
        check("s2_issue_count", 64'(gap_q.size()), 64'(3));
        if (gap_q.size() == 3) begin
            check("s2_gap1", 64'(gap_q[1] - gap_q[0]), 64'(lat + RG + 1));
            check("s2_gap2", 64'(gap_q[2] - gap_q[1]), 64'(lat + RG + 1));
        end

        // Entry 4 always NACKs.
        do_reset(); load(3); lat = 5; c5 = cnt5;
        start_pulse();
        wait_idle("s3_finish", 3000);
        check("s3_done_err_busy", 64'({seq_done, seq_error, busy}), 64'(3'b010));
        check("s3_fail_index", 64'(fail_index), 64'(4));
        check("s3_no_fetch_e5", 64'(cnt5 - c5), 64'(0));
        run_check(3);

        // Reset and start together: reset wins and clears the error.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_start_idle", 64'({busy, seq_done, seq_error, fail_index, rom_addr, bus.cmd_valid}), 64'(0));
        tick();
        check("rst_start_stays_idle", 64'(busy), 64'(0));

        // Back-pressure for 50 clocks with a stray done/NACK mid-issue.
        load(4); lat = 5; cmd_ready = 1'b0;
        start_pulse();
        n = 0;
        while (!bus.cmd_valid && n < 10) begin
            tick();
            n++;
        end
        check("s5_valid_rises", 64'(bus.cmd_valid), 64'(1));
        f = {bus.cmd_dev_addr, bus.cmd_reg_addr, bus.cmd_data};
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            stray_done = (i == 10);
            stray_nack = (i == 10);
            tick();
            if (!bus.cmd_valid || {bus.cmd_dev_addr, bus.cmd_reg_addr, bus.cmd_data} != f || rom_addr != 6'd0)
                stable = 1'b0;
        end
        stray_done = 1'b0; stray_nack = 1'b0;
        check("s5_stable_50", 64'(stable), 64'(1));
        check("s5_first_fields", 64'(f), 64'({DA, 8'h40, 8'h5A}));
        cmd_ready = 1'b1;
        wait_idle("s5_finish", 2000);
        check("s5_done_err", 64'({seq_done, seq_error}), 64'(2'b10));
        run_check(4);

        // Start while busy is ignored; reset in WAIT_DONE returns to idle.
        do_reset(); load(4); lat = 30;
        start_pulse();
        n = 0;
        while (!bus.cmd_valid && n < 10) begin
            tick();
            n++;
        end
        tick(); tick(); tick(); tick();
        start_pulse();
        check("s6_start_busy", 64'({busy, rom_addr, bus.cmd_valid}), 64'({1'b1, 6'd0, 1'b0}));
        tick();
        check("s6_no_restart", 64'({busy, rom_addr, bus.cmd_valid}), 64'({1'b1, 6'd0, 1'b0}));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_reset_idle", 64'({busy, seq_done, seq_error, fail_index, rom_addr, bus.cmd_valid}), 64'(0));
        for (int i = 0; i < 40; i++) tick();
        check("s6_post_reset_busy", 64'(busy), 64'(0));
        check("s6_one_accept", 64'(acc_q.size()), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
